llsc_ctrl: RTL
==============

Name: llsc_ctrl

Overview:
- Load-linked/store-conditional reservation controller for the MEM stage.
- Records the link address on LL and decides SC success in the same cycle.
- Kills the reservation on exception flush, on a matching remote write (snoop), or on a timeout.
- Drives the LLbit register write port at WB timing and keeps a saturating SC-failure counter for CP0/debug.

Parameters:
- ADDR_W, 32, address width.
- GRAN_LSB, 2, low address bits ignored in every address compare (word granule).
- TIMEOUT, 1024, cycles a reservation survives without an SC. 0 disables the timeout.
- CNT_W, 16, width of the SC-failure counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  exception/ERET flush from ctrl; squashes the current MEM instruction.
- ll_valid_i  in  1  LL executing in MEM this cycle (one-cycle pulse per instruction).
- ll_addr_i  in  ADDR_W  LL effective address.
- sc_valid_i  in  1  SC executing in MEM this cycle (one-cycle pulse per instruction).
- sc_addr_i  in  ADDR_W  SC effective address.
- snoop_valid_i  in  1  remote master write observed on the bus.
- snoop_addr_i  in  ADDR_W  remote write address.
- sc_ok_o  out  1  combinational: this SC succeeds; gates the memory write and the rt result (1/0).
- link_valid_o  out  1  reservation held (state == LINKED).
- link_addr_o  out  ADDR_W  current link address.
- llbit_we_o  out  1  registered write enable to the LLbit register.
- llbit_wdata_o  out  1  registered LLbit write value.
- sc_fail_cnt_o  out  CNT_W  saturating count of failed SCs.

Behaviour:
- Reset is synchronous and active-high (`rst`, `RstEnable`) on clock `clk`.
  - State goes to IDLE.
  - link_addr_o, timer, llbit_we_o, llbit_wdata_o and sc_fail_cnt_o all reset to 0.
  - A reset mid-reservation drops the link with no LLbit write.
- States: IDLE (no reservation) and LINKED.
- Address match compares only bits [ADDR_W-1:GRAN_LSB].
- Per-cycle priority: rst > flush > sc_valid_i > ll_valid_i > snoop hit > timeout.
- flush:
  - Next state IDLE; any same-cycle LL/SC is ignored.
  - sc_ok_o = 0; no failure count is recorded.
  - llbit_we_o = 1, llbit_wdata_o = 0 next cycle.
- SC in IDLE or LINKED:
  - Next state is always IDLE (an SC consumes the reservation).
  - sc_ok_o = LINKED & addr match & !snoop hit this cycle.
  - Next cycle: llbit_we_o = 1, wdata = 0.
  - On failure, sc_fail_cnt_o increments next cycle, saturating at all-ones.
- LL (no flush, no SC):
  - Next state LINKED; link_addr <= ll_addr_i; timer <= 0.
  - Next cycle: llbit_we_o = 1, wdata = 1.
  - A same-cycle snoop to the same address is ordered before the LL, so the link stands.
  - LL while already LINKED re-links to the new address and restarts the timer.
- Snoop hit (LINKED, snoop_valid_i, addr match, no LL/SC):
  - Next state IDLE; LLbit write 0 next cycle.
  - Non-matching snoops are ignored.
- Timeout:
  - The timer counts cycles in LINKED, starting at 0 in the first LINKED cycle.
  - When timer == TIMEOUT-1 with no other event, next state is IDLE and LLbit is written 0.
  - With LL accepted at cycle t, an SC at cycle t+k succeeds for 1 <= k <= TIMEOUT and fails for k > TIMEOUT.
  - The timer saturates; it never wraps.
- llbit_we_o is a one-cycle pulse and is 0 in cycles with no event.
- sc_valid_i and ll_valid_i asserted together is illegal (bench asserts); the SC takes priority.

Decomposition:
- defines.v gains:
  - the state encodings `LlscIdle` / `LlscLinked`;
  - `LlscTimeoutDefault` 1024;
  - `LlscGranLsb` 2.
- One sub-module, llsc_timer:
  - clear/enable inputs, expire output;
  - a counter of clog2(TIMEOUT) bits, tied off when TIMEOUT = 0.

Test Plan:
- LL 0x1000 at cycle 5, SC 0x1000 at cycle 8:
  - sc_ok_o = 1 at cycle 8;
  - llbit_we_o/wdata = 1/1 at cycle 6 and 1/0 at cycle 9;
  - link_valid_o = 0 from cycle 9.
- LL 0x1000, snoop 0x1002 (same word), then SC 0x1000 → sc_ok_o = 0 and sc_fail_cnt_o = 1.
- LL 0x1000, snoop 0x1004 → link kept; the later SC succeeds.
- LL 0x2000, then flush in the same cycle as SC 0x2000 → sc_ok_o = 0; fail count unchanged; LLbit written 0.
- TIMEOUT = 4, LL at cycle 0:
  - SC at cycle 4 → ok = 1.
  - Rerun with SC at cycle 5 → ok = 0, link_valid_o already 0.
- Other cases:
  - SC with no prior LL → ok = 0 and the counter increments.
  - 0xFFFF failures → counter stays at 0xFFFF.
  - rst during LINKED → link_valid_o = 0 with no llbit_we_o pulse.

Source files
------------

// File: rtl/llsc_ctrl_pkg.sv
// Shared types and defaults for the LL/SC reservation controller.
package llsc_ctrl_pkg;

  typedef enum logic {
    LlscIdle   = 1'b0,
    LlscLinked = 1'b1
  } llsc_state_e;

  localparam int unsigned LlscTimeoutDefault = 1024;
  localparam int unsigned LlscGranLsb        = 2;

  // Counter width for a timeout of n cycles; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/llsc_timer.sv
// Reservation age counter: counts LINKED cycles and flags the last surviving cycle.
module llsc_timer
  import llsc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = LlscTimeoutDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst ^ clear ^ enable;
      assign expire      = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = timer_width(TIMEOUT);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q;

      // Saturates at LAST so a stale count can never wrap back into range.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (clear) begin
          cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      assign expire = enable && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/llsc_ctrl.sv
// LL/SC reservation controller for the MEM stage: link tracking, SC decision,
// LLbit write-back and saturating SC-failure counter.
module llsc_ctrl
  import llsc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned GRAN_LSB = LlscGranLsb,
  parameter int unsigned TIMEOUT  = LlscTimeoutDefault,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ll_valid_i,
  input  logic [ADDR_W-1:0] ll_addr_i,
  input  logic              sc_valid_i,
  input  logic [ADDR_W-1:0] sc_addr_i,
  input  logic              snoop_valid_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              sc_ok_o,
  output logic              link_valid_o,
  output logic [ADDR_W-1:0] link_addr_o,
  output logic              llbit_we_o,
  output logic              llbit_wdata_o,
  output logic [CNT_W-1:0]  sc_fail_cnt_o
);

  llsc_state_e       state_q, state_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              llbit_we_d, llbit_wdata_d;
  logic              linked_c, sc_match_c, snoop_hit_c, timer_clr_c, expire_c;

  // Word-granule compares: bits below GRAN_LSB are shifted out of the difference.
  assign linked_c    = (state_q == LlscLinked);
  assign sc_match_c  = ((sc_addr_i ^ link_addr_q) >> GRAN_LSB) == '0;
  assign snoop_hit_c = linked_c && snoop_valid_i &&
                       (((snoop_addr_i ^ link_addr_q) >> GRAN_LSB) == '0);
  assign sc_ok_o     = linked_c && sc_valid_i && !flush && sc_match_c && !snoop_hit_c;

  llsc_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clr_c),
    .enable(linked_c),
    .expire(expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LlscIdle;
      link_addr_q   <= '0;
      fail_cnt_q    <= '0;
      llbit_we_o    <= 1'b0;
      llbit_wdata_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      link_addr_q   <= link_addr_d;
      fail_cnt_q    <= fail_cnt_d;
      llbit_we_o    <= llbit_we_d;
      llbit_wdata_o <= llbit_wdata_d;
    end
  end

  // Event priority: flush > SC > LL > snoop hit > timeout.
  always_comb begin
    state_d       = state_q;
    link_addr_d   = link_addr_q;
    fail_cnt_d    = fail_cnt_q;
    llbit_we_d    = 1'b0;
    llbit_wdata_d = 1'b0;
    timer_clr_c   = 1'b0;

    if (flush) begin
      state_d    = LlscIdle;
      llbit_we_d = 1'b1;
    end else if (sc_valid_i) begin
      state_d    = LlscIdle;
      llbit_we_d = 1'b1;
      if (!sc_ok_o && (fail_cnt_q != '1)) begin
        fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
    end else if (ll_valid_i) begin
      state_d       = LlscLinked;
      link_addr_d   = ll_addr_i;
      timer_clr_c   = 1'b1;
      llbit_we_d    = 1'b1;
      llbit_wdata_d = 1'b1;
    end else if (snoop_hit_c) begin
      state_d    = LlscIdle;
      llbit_we_d = 1'b1;
    end else if (linked_c && expire_c) begin
      state_d    = LlscIdle;
      llbit_we_d = 1'b1;
    end
  end

  assign link_valid_o  = linked_c;
  assign link_addr_o   = link_addr_q;
  assign sc_fail_cnt_o = fail_cnt_q;

endmodule
